// File: rtl/snake_apple_field.sv
// snake_apple_field: multi-apple placement, eat detection and scoring.
// Apples respawn at pseudo-random free interior cells from a Galois LFSR.
module snake_apple_field #(
  parameter int          GRID_W       = 40,
  parameter int          GRID_H       = 30,
  parameter int          X_W          = 6,
  parameter int          Y_W          = 5,
  parameter int          NUM_APPLES   = 4,
  parameter int          TICK_DIV     = 250000,
  parameter int          MAX_TRY      = 16,
  parameter int          BONUS_PERIOD = 8,
  parameter int          SCORE_W      = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                        CLK_50M,
  input  logic                        RST,
  input  logic                        enable,
  input  logic [X_W-1:0]              head_x,
  input  logic [Y_W-1:0]              head_y,
  output logic [NUM_APPLES*X_W-1:0]   apple_x,
  output logic [NUM_APPLES*Y_W-1:0]   apple_y,
  output logic [NUM_APPLES-1:0]       apple_valid,
  output logic [NUM_APPLES-1:0]       apple_bonus,
  output logic                        add_cube,
  output logic [2:0]                  eat_idx,
  output logic [SCORE_W-1:0]          score
);

  localparam int TW  = $clog2(TICK_DIV);
  localparam int RW  = $clog2(MAX_TRY + 1);
  localparam int BW  = $clog2(BONUS_PERIOD + 1);
  localparam int IW  = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;
  localparam int SW1 = SCORE_W + 1;

  typedef enum logic {IDLE, GEN} state_t;

  state_t                    state_q, state_d;
  logic [TW-1:0]             cnt_q, cnt_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [IW-1:0]             gidx_q, gidx_d;
  logic [RW-1:0]             try_q, try_d;
  logic [BW-1:0]             spawn_q, spawn_d;
  logic                      add_cube_q, add_cube_d;
  logic [2:0]                eat_idx_q, eat_idx_d;
  logic [SCORE_W-1:0]        score_q, score_d;
  logic [NUM_APPLES*X_W-1:0] ax_q, ax_d;
  logic [NUM_APPLES*Y_W-1:0] ay_q, ay_d;
  logic [NUM_APPLES-1:0]     valid_q, valid_d;
  logic [NUM_APPLES-1:0]     bonus_q, bonus_d;
  logic [NUM_APPLES-1:0]     pend_q, pend_d;

  logic                      tick;
  logic                      hit;
  logic [IW-1:0]             hit_idx;
  logic [IW-1:0]             pend_idx;
  logic [X_W-1:0]            cx;
  logic [Y_W-1:0]            cy;
  logic                      bad;
  logic [SCORE_W:0]          sum;

  assign tick = enable && (cnt_q == TW'(TICK_DIV - 1));

  // Game tick divider: counts only while the game is running
  always_comb begin
    cnt_d = cnt_q;
    if (enable)
      cnt_d = (cnt_q == TW'(TICK_DIV - 1)) ? '0 : cnt_q + 1'b1;
  end

  // Free-running Galois LFSR, taps 16'hB400
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Lowest-index apple under the head, and lowest pending apple
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    pend_idx = '0;
    for (int i = NUM_APPLES - 1; i >= 0; i--) begin
      if (valid_q[i] &&
          ax_q[i*X_W +: X_W] == head_x &&
          ay_q[i*Y_W +: Y_W] == head_y) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (pend_q[i])
        pend_idx = IW'(i);
    end
  end

  // Candidate cell and its rejection test
  always_comb begin
    cx  = lfsr_q[X_W-1:0];
    cy  = lfsr_q[X_W+Y_W-1:X_W];
    bad = (cx == '0) || (cx >= X_W'(GRID_W - 1)) ||
          (cy == '0) || (cy >= Y_W'(GRID_H - 1)) ||
          (cx == head_x && cy == head_y);
    for (int i = 0; i < NUM_APPLES; i++)
      if (valid_q[i] && IW'(i) != gidx_q &&
          ax_q[i*X_W +: X_W] == cx &&
          ay_q[i*Y_W +: Y_W] == cy)
        bad = 1'b1;
  end

  // Eat / respawn FSM; ticks outside IDLE are ignored
  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    try_d      = try_q;
    spawn_d    = spawn_q;
    add_cube_d = 1'b0;
    eat_idx_d  = eat_idx_q;
    score_d    = score_q;
    ax_d       = ax_q;
    ay_d       = ay_q;
    valid_d    = valid_q;
    bonus_d    = bonus_q;
    pend_d     = pend_q;
    sum        = {1'b0, score_q} +
                 (bonus_q[hit_idx] ? SW1'(3) : SW1'(1));
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          if (hit) begin
            add_cube_d = 1'b1;
            eat_idx_d  = 3'(hit_idx);
            for (int i = 0; i < NUM_APPLES; i++)
              if (IW'(i) == hit_idx) begin
                valid_d[i] = 1'b0;
                pend_d[i]  = 1'b1;
              end
            score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
            state_d = GEN;
            gidx_d  = hit_idx;
            try_d   = '0;
          end else if (|pend_q) begin
            state_d = GEN;
            gidx_d  = pend_idx;
            try_d   = '0;
          end
        end
      end
      GEN: begin
        if (!bad) begin
          for (int i = 0; i < NUM_APPLES; i++)
            if (IW'(i) == gidx_q) begin
              ax_d[i*X_W +: X_W] = cx;
              ay_d[i*Y_W +: Y_W] = cy;
              valid_d[i] = 1'b1;
              pend_d[i]  = 1'b0;
              bonus_d[i] = (spawn_q == BW'(BONUS_PERIOD - 1));
            end
          spawn_d = (spawn_q == BW'(BONUS_PERIOD - 1)) ?
                    '0 : spawn_q + 1'b1;
          state_d = IDLE;
        end else if (try_q == RW'(MAX_TRY - 1)) begin
          state_d = IDLE;
        end else begin
          try_d = try_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      gidx_q     <= '0;
      try_q      <= '0;
      spawn_q    <= '0;
      add_cube_q <= 1'b0;
      eat_idx_q  <= '0;
      score_q    <= '0;
      valid_q    <= '1;
      bonus_q    <= '0;
      pend_q     <= '0;
      for (int i = 0; i < NUM_APPLES; i++) begin
        ax_q[i*X_W +: X_W] <=
          X_W'((2*i + 1) * GRID_W / (2 * NUM_APPLES));
        ay_q[i*Y_W +: Y_W] <= Y_W'(GRID_H / 3);
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      gidx_q     <= gidx_d;
      try_q      <= try_d;
      spawn_q    <= spawn_d;
      add_cube_q <= add_cube_d;
      eat_idx_q  <= eat_idx_d;
      score_q    <= score_d;
      valid_q    <= valid_d;
      bonus_q    <= bonus_d;
      pend_q     <= pend_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
    end
  end

  assign apple_x     = ax_q;
  assign apple_y     = ay_q;
  assign apple_valid = valid_q;
  assign apple_bonus = bonus_q;
  assign add_cube    = add_cube_q;
  assign eat_idx     = eat_idx_q;
  assign score       = score_q;

endmodule

// File: tb/tb_snake_apple_field.sv
// tb_snake_apple_field: scoreboard bench with a behavioural game model.
// Small grid and score width make respawn deferral and saturation common.
module tb_snake_apple_field;

  localparam int GW = 12;
  localparam int GH = 6;
  localparam int XW = 5;
  localparam int YW = 3;
  localparam int NA = 4;
  localparam int TD = 24;
  localparam int MT = 16;
  localparam int BP = 8;
  localparam int SW = 5;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [XW-1:0] hx;
  logic [YW-1:0] hy;
  logic [NA*XW-1:0] ax;
  logic [NA*YW-1:0] ay;
  logic [NA-1:0] av;
  logic [NA-1:0] ab;
  logic add_cube;
  logic [2:0] eat_idx;
  logic [SW-1:0] score;

  always #5 clk = ~clk;

  snake_apple_field #(
    .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW),
    .NUM_APPLES(NA), .TICK_DIV(TD), .MAX_TRY(MT),
    .BONUS_PERIOD(BP), .SCORE_W(SW), .LFSR_SEED(16'hACE1)
  ) dut (
    .CLK_50M(clk), .RST(rst), .enable(en),
    .head_x(hx), .head_y(hy),
    .apple_x(ax), .apple_y(ay),
    .apple_valid(av), .apple_bonus(ab),
    .add_cube(add_cube), .eat_idx(eat_idx), .score(score)
  );

  typedef struct { int idx; int sc; } eat_t;
  typedef struct { int idx; int x; int y; int b; } spn_t;

  eat_t eat_q[$];
  spn_t spn_q[$];

  int total = 0;
  int bad = 0;
  int pulses = 0;

  int m_cnt, m_gidx, m_try, m_spawn, m_score, m_defer;
  bit m_gen;
  logic [15:0] m_lfsr;
  int mx[NA];
  int my[NA];
  bit mv[NA];
  bit mb[NA];
  bit mp[NA];
  bit rst_edge = 1'b1;

  function automatic void chk(bit ok, string nm, int act, int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int rx(int i);
    return (2*i + 1) * GW / (2*NA);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_lfsr = 16'hACE1; m_gen = 0; m_gidx = 0;
    m_try = 0; m_spawn = 0; m_score = 0;
    for (int i = 0; i < NA; i++) begin
      mx[i] = rx(i); my[i] = GH / 3;
      mv[i] = 1; mb[i] = 0; mp[i] = 0;
    end
    eat_q.delete();
    spn_q.delete();
  endtask

  task automatic model_step();
    bit tick;
    bit ok;
    int cx, cy, m, p;
    eat_t e;
    spn_t s;
    tick = en && (m_cnt == TD - 1);
    cx = int'(m_lfsr[XW-1:0]);
    cy = int'(m_lfsr[XW+YW-1:XW]);
    if (en) m_cnt = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
    if (!m_gen) begin
      if (tick) begin
        m = -1; p = -1;
        for (int i = 0; i < NA; i++) begin
          if (m < 0 && mv[i] && mx[i] == int'(hx) && my[i] == int'(hy)) m = i;
          if (p < 0 && mp[i]) p = i;
        end
        if (m >= 0) begin
          m_score = m_score + (mb[m] ? 3 : 1);
          if (m_score > SMAX) m_score = SMAX;
          mv[m] = 0; mp[m] = 1;
          e.idx = m; e.sc = m_score;
          eat_q.push_back(e);
          m_gen = 1; m_gidx = m; m_try = 0;
        end else if (p >= 0) begin
          m_gen = 1; m_gidx = p; m_try = 0;
        end
      end
    end else begin
      ok = cx > 0 && cx < GW - 1 && cy > 0 && cy < GH - 1 &&
           !(cx == int'(hx) && cy == int'(hy));
      for (int i = 0; i < NA; i++)
        if (i != m_gidx && mv[i] && mx[i] == cx && my[i] == cy) ok = 0;
      if (ok) begin
        mx[m_gidx] = cx; my[m_gidx] = cy;
        mv[m_gidx] = 1; mp[m_gidx] = 0;
        mb[m_gidx] = (m_spawn == BP - 1);
        m_spawn = (m_spawn + 1) % BP;
        s.idx = m_gidx; s.x = cx; s.y = cy; s.b = int'(mb[m_gidx]);
        spn_q.push_back(s);
        m_gen = 0;
      end else begin
        m_try++;
        if (m_try == MT) begin m_gen = 0; m_defer++; end
      end
    end
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endtask

  // Reference model advances on every rising edge
  initial begin
    m_defer = 0;
    forever begin
      @(posedge clk);
      rst_edge = rst;
      if (rst) model_reset();
      else model_step();
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event
  initial begin
    logic [NA-1:0] pv;
    eat_t e;
    spn_t s;
    bit fok;
    int vexp;
    pv = '1;
    forever begin
      @(negedge clk);
      if (!rst && !rst_edge) begin
        if (add_cube) begin
          pulses++;
          if (eat_q.size() == 0) chk(0, "eat_unexpected", int'(eat_idx), -1);
          else begin
            e = eat_q.pop_front();
            chk(int'(eat_idx) == e.idx, "eat_idx", int'(eat_idx), e.idx);
            chk(int'(score) == e.sc, "eat_score", int'(score), e.sc);
          end
        end
        for (int i = 0; i < NA; i++)
          if (av[i] && !pv[i]) begin
            if (spn_q.size() == 0) chk(0, "spawn_unexpected", i, -1);
            else begin
              s = spn_q.pop_front();
              chk(i == s.idx, "spawn_idx", i, s.idx);
              chk(int'(ax[i*XW +: XW]) == s.x, "spawn_x", int'(ax[i*XW +: XW]), s.x);
              chk(int'(ay[i*YW +: YW]) == s.y, "spawn_y", int'(ay[i*YW +: YW]), s.y);
              chk(int'(ab[i]) == s.b, "spawn_bonus", int'(ab[i]), s.b);
            end
          end
        vexp = 0;
        for (int i = 0; i < NA; i++) if (mv[i]) vexp |= (1 << i);
        chk(int'(av) == vexp, "valid_vec", int'(av), vexp);
        fok = 1;
        for (int i = 0; i < NA; i++) if (av[i]) begin
          if (ax[i*XW +: XW] == 0 || int'(ax[i*XW +: XW]) >= GW - 1 ||
              ay[i*YW +: YW] == 0 || int'(ay[i*YW +: YW]) >= GH - 1) fok = 0;
          for (int j = i + 1; j < NA; j++)
            if (av[j] && ax[i*XW +: XW] == ax[j*XW +: XW] &&
                ay[i*YW +: YW] == ay[j*YW +: YW]) fok = 0;
        end
        if (!fok) chk(0, "field_layout", int'(av), -1);
      end
      pv = av;
    end
  end

  task automatic check_reset_vals(string tag);
    for (int i = 0; i < NA; i++) begin
      chk(int'(ax[i*XW +: XW]) == rx(i), {tag, "_x"}, int'(ax[i*XW +: XW]), rx(i));
      chk(int'(ay[i*YW +: YW]) == GH / 3, {tag, "_y"}, int'(ay[i*YW +: YW]), GH / 3);
    end
    chk(int'(av) == (1 << NA) - 1, {tag, "_valid"}, int'(av), (1 << NA) - 1);
    chk(ab == '0, {tag, "_bonus"}, int'(ab), 0);
    chk(score == '0, {tag, "_score"}, int'(score), 0);
    chk(add_cube == 1'b0, {tag, "_add"}, int'(add_cube), 0);
    chk(eat_idx == 3'd0, {tag, "_eidx"}, int'(eat_idx), 0);
  endtask

  task automatic wait_pulse(int bound, string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!add_cube && n < bound) begin @(negedge clk); n++; end
    chk(add_cube == 1'b1, nm, int'(add_cube), 1);
  endtask

  // Wait for an idle model with a valid apple; return its index or -1
  task automatic find_apple(output int k);
    int n;
    k = -1; n = 0;
    while (k < 0 && n < 40 * TD) begin
      if (!m_gen)
        for (int i = 0; i < NA; i++) if (k < 0 && mv[i]) k = i;
      if (k < 0) begin @(negedge clk); n++; end
    end
  endtask

  task automatic eat_one();
    int k;
    find_apple(k);
    if (k < 0) chk(0, "no_apple", k, 0);
    else begin
      hx = XW'(mx[k]); hy = YW'(my[k]);
      wait_pulse(2 * TD, "eat_pulse_timeout");
    end
  endtask

  initial begin
    int p0, s0, k, r, nx, ny;
    rst = 1; en = 0; hx = 1; hy = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    check_reset_vals("rst");

    en = 1;
    p0 = pulses;
    repeat (3 * TD + 2) @(negedge clk);
    @(negedge clk);
    chk(pulses == p0, "no_eat_pulses", pulses - p0, 0);

    hx = XW'(rx(1)); hy = YW'(GH / 3);
    wait_pulse(2 * TD, "t2_pulse");
    chk(eat_idx == 3'd1, "t2_idx", int'(eat_idx), 1);
    chk(int'(score) == 1, "t2_score", int'(score), 1);
    chk(av[1] == 1'b0, "t2_invalid", int'(av[1]), 0);
    repeat (MT + 1) @(negedge clk);

    for (int n = 0; n < 80 && !(m_score == SMAX && m_defer > 0); n++)
      eat_one();
    eat_one();
    @(negedge clk);
    chk(int'(score) == SMAX, "score_sat", int'(score), SMAX);

    find_apple(k);
    en = 0;
    if (k < 0) chk(0, "t5_no_apple", k, 0);
    else begin
      hx = XW'(mx[k]); hy = YW'(my[k]);
    end
    p0 = pulses; s0 = int'(score);
    repeat (5 * TD) @(negedge clk);
    chk(pulses == p0, "disabled_pulses", pulses - p0, 0);
    chk(int'(score) == s0, "disabled_score", int'(score), s0);

    en = 1;
    wait_pulse(2 * TD, "t5_pulse");
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_reset_vals("gen_rst");
    rst = 0;
    hx = 1; hy = 1;

    for (int t = 0; t < 1200; t++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin
        k = -1;
        for (int i = 0; i < NA; i++) if (k < 0 && mv[i]) k = i;
        if (k >= 0) begin hx = XW'(mx[k]); hy = YW'(my[k]); end
      end else begin
        nx = int'(hx); ny = int'(hy);
        case (r % 4)
          0: nx++;
          1: nx--;
          2: ny++;
          default: ny--;
        endcase
        if (nx < 1) nx = 1;
        if (nx > GW - 2) nx = GW - 2;
        if (ny < 1) ny = 1;
        if (ny > GH - 2) ny = GH - 2;
        hx = XW'(nx); hy = YW'(ny);
      end
      repeat (TD) @(negedge clk);
    end

    en = 0;
    repeat (MT + 4) @(negedge clk);
    chk(eat_q.size() == 0, "eat_drain", eat_q.size(), 0);
    chk(spn_q.size() == 0, "spawn_drain", spn_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_apple_field.md
Name: snake_apple_field

Overview:
Parametrised successor to the single-apple generator in the snake game. It manages NUM_APPLES apples on a GRID_W x GRID_H board and detects when the head eats one. On each eat it issues a growth pulse, adds to the score and respawns the apple at a pseudo-random free cell. Respawn rejects border cells, the head cell and cells occupied by other apples; every BONUS_PERIOD-th spawn is a bonus apple. It sits between the snake movement logic, which supplies the head position, and the VGA renderer, which consumes the apple positions.

Parameters:
GRID_W, 40, board width in cells; columns 0 and GRID_W-1 are walls.
GRID_H, 30, board height in cells; rows 0 and GRID_H-1 are walls.
X_W, 6, x coordinate width; must satisfy 2^X_W >= GRID_W.
Y_W, 5, y coordinate width; must satisfy 2^Y_W >= GRID_H.
NUM_APPLES, 4, number of simultaneous apples (1..8).
TICK_DIV, 250000, CLK_50M cycles per game tick; must be > MAX_TRY+4.
MAX_TRY, 16, candidate attempts per respawn before the respawn is deferred.
BONUS_PERIOD, 8, every BONUS_PERIOD-th successful spawn is a bonus apple.
SCORE_W, 16, score width.
LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
CLK_50M  in  1  system clock.
RST  in  1  reset; synchronous, active-high.
enable  in  1  game running; when low, the tick counter holds and no eat is detected.
head_x  in  X_W  snake head column.
head_y  in  Y_W  snake head row.
apple_x  out  NUM_APPLES*X_W  apple i column at bits [i*X_W +: X_W].
apple_y  out  NUM_APPLES*Y_W  apple i row at bits [i*Y_W +: Y_W].
apple_valid  out  NUM_APPLES  apple i present on the board.
apple_bonus  out  NUM_APPLES  apple i is a bonus apple.
add_cube  out  1  one-cycle pulse: snake grows by one.
eat_idx  out  3  index of the last eaten apple; valid when add_cube=1.
score  out  SCORE_W  accumulated score, saturating.

Behaviour:
- Reset (RST=1 at a clock edge): tick counter = 0; LFSR = LFSR_SEED; FSM = IDLE; spawn counter = 0; add_cube = 0; eat_idx = 0; score = 0; apple_bonus = 0; apple_valid = all ones; pending = 0.
- Reset apple positions: apple i x = (2i+1)*GRID_W/(2*NUM_APPLES), y = GRID_H/3. For the defaults this gives x = 5, 15, 25, 35 and y = 10.
- Reset mid-respawn aborts the respawn and restores the full reset state.
- LFSR: 16-bit Galois, mask 16'hB400. It shifts every cycle while RST=0, regardless of enable or FSM state.
- Tick: while enable=1 the counter increments; at TICK_DIV-1 it wraps to 0 and asserts tick for one cycle. When enable=0 the counter holds.
- FSM IDLE, on tick: compare the head with every valid apple and take the lowest matching index m.
  - Match: next cycle add_cube=1, eat_idx=m, apple_valid[m]=0, pending[m]=1. Score += 3 if apple_bonus[m] else 1, saturating at 2^SCORE_W-1. FSM goes to GEN for apple m.
  - No match and pending is nonzero: FSM goes to GEN for the lowest pending index; no pulse.
  - Otherwise stay in IDLE.
- add_cube is high exactly one cycle per eat and is never high outside the cycle after a tick.
- FSM GEN: one candidate per cycle, taken from the current LFSR value: cx = lfsr[X_W-1:0], cy = lfsr[X_W+Y_W-1:X_W].
  - Reject if cx==0, cx>=GRID_W-1, cy==0, cy>=GRID_H-1, (cx,cy) equals the head, or (cx,cy) equals any other valid apple.
  - Accept: at the next edge load the apple coordinates, set valid=1 and clear its pending bit. Set bonus=1 iff spawn counter==BONUS_PERIOD-1. Spawn counter increments modulo BONUS_PERIOD. FSM returns to IDLE.
  - Reject: increment the try count. After MAX_TRY rejections return to IDLE with pending still set; the retry happens on the next tick.
- Latency: a tick at cycle T gives add_cube at T+1; the new apple is visible no earlier than T+2 and no later than T+MAX_TRY+1.
- Since TICK_DIV > MAX_TRY+4, no tick arrives outside IDLE; the RTL must still ignore any such tick.
- Invalid or pending apples are never eaten.
- Two valid apples never share a cell, so multiple simultaneous matches cannot occur. Lowest-index priority is still implemented.
- Dropping enable mid-GEN does not stop GEN; it completes normally.

Test Plan:
1. Apply reset and release; check outputs: apple_x = {35,25,15,5}, apple_y = {10,10,10,10}, apple_valid=4'b1111, score=0, add_cube=0. Then hold the head at (1,1) for 3 ticks; expect no add_cube pulse.
2. Set the head to (15,10) before a tick. Expect add_cube for one cycle at T+1, eat_idx=1, score=1, apple_valid[1]=0. Apple 1 must reappear within MAX_TRY+1 cycles at x in 1..38, y in 1..28, not on (15,10) and not on any other apple.
3. Run eight successive eats. Only the 8th spawn has apple_bonus=1; eating it raises the score by 3. Preload the score near 2^16-1 and eat; the score holds at 65535.
4. Force the LFSR (bench hook) so that MAX_TRY candidates are all walls. Apple stays invalid with pending=1 and FSM returns to IDLE. On the next tick, with the head elsewhere, the respawn succeeds with no add_cube pulse.
5. Pull enable low with the head on an apple for 5*TICK_DIV cycles: no pulse, score unchanged. Assert RST three cycles into GEN: outputs return to the test-1 values on the next edge.
6. Random soak of 10^5 ticks with a random-walk head. Check continuously: valid apples are pairwise distinct and never on walls, and each add_cube pulse increments the score by exactly 1 or 3.
